// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are
// valid, snoops the CDB for missing operands, issues one ready op per cycle.
module alu_reservation_station #(
   parameter int RSsize     = 4,
   parameter int ROBsize    = 32,
   parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic                         dispatchValid_i,
   input  logic [9:0]                   dispatchCommands_i,
   input  logic [ROBsizeLog-1:0]        dispatchTag_i,
   input  logic [63:0]                  dispatchVal1_i,
   input  logic [63:0]                  dispatchVal2_i,
   input  logic                         dispatchRdy1_i,
   input  logic                         dispatchRdy2_i,
   input  logic [ROBsizeLog-1:0]        dispatchSrc1_i,
   input  logic [ROBsizeLog-1:0]        dispatchSrc2_i,
   output logic                         rsFull_o,
   output logic [$clog2(RSsize+1)-1:0]  rsCount_o,
   input  logic                         cdbValid_i,
   input  logic [ROBsizeLog-1:0]        cdbTag_i,
   input  logic [63:0]                  cdbVal_i,
   input  logic                         stallRS_i,
   output logic [63:0]                  reservationStationVal1_o,
   output logic [63:0]                  reservationStationVal2_o,
   output logic [9:0]                   reservationStationCommands_o,
   output logic [ROBsizeLog-1:0]        reservationStationTag_o,
   output logic                         readyRS_o
);

   localparam int CntW = $clog2(RSsize + 1);
   localparam int IdxW = (RSsize > 1) ? $clog2(RSsize) : 1;

   logic [RSsize-1:0]     busy;
   logic [RSsize-1:0]     rdy1;
   logic [RSsize-1:0]     rdy2;
   logic [9:0]            cmdQ  [RSsize];
   logic [ROBsizeLog-1:0] tagQ  [RSsize];
   logic [ROBsizeLog-1:0] src1Q [RSsize];
   logic [ROBsizeLog-1:0] src2Q [RSsize];
   logic [63:0]           val1Q [RSsize];
   logic [63:0]           val2Q [RSsize];

   logic [CntW-1:0] count;
   logic [IdxW-1:0] freeIdx;
   logic [IdxW-1:0] selIdx;
   logic            anyReady;
   logic            doDisp;
   logic            doIssue;
   logic            disp1Hit;
   logic            disp2Hit;

   // Reverse scan so the lowest index wins for both free slot and select.
   always_comb begin
      count    = '0;
      freeIdx  = '0;
      selIdx   = '0;
      anyReady = 1'b0;
      for (int i = RSsize - 1; i >= 0; i--) begin
         count = count + CntW'(busy[i]);
         if (!busy[i]) freeIdx = IdxW'(i);
         if (busy[i] && rdy1[i] && rdy2[i]) begin
            selIdx   = IdxW'(i);
            anyReady = 1'b1;
         end
      end
   end

   assign rsCount_o = count;
   assign rsFull_o  = (count == CntW'(RSsize));
   assign doDisp    = dispatchValid_i && !rsFull_o;
   assign doIssue   = !stallRS_i && anyReady;

   assign disp1Hit = cdbValid_i && !dispatchRdy1_i &&
                     (dispatchSrc1_i == cdbTag_i);
   assign disp2Hit = cdbValid_i && !dispatchRdy2_i &&
                     (dispatchSrc2_i == cdbTag_i);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy <= '0;
         rdy1 <= '0;
         rdy2 <= '0;
         for (int i = 0; i < RSsize; i++) begin
            cmdQ[i]  <= '0;
            tagQ[i]  <= '0;
            src1Q[i] <= '0;
            src2Q[i] <= '0;
            val1Q[i] <= '0;
            val2Q[i] <= '0;
         end
      end else if (flush_i) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < RSsize; i++) begin
            if (cdbValid_i && busy[i]) begin
               if (!rdy1[i] && src1Q[i] == cdbTag_i) begin
                  rdy1[i]  <= 1'b1;
                  val1Q[i] <= cdbVal_i;
               end
               if (!rdy2[i] && src2Q[i] == cdbTag_i) begin
                  rdy2[i]  <= 1'b1;
                  val2Q[i] <= cdbVal_i;
               end
            end
         end
         if (doIssue) busy[selIdx] <= 1'b0;
         // Free slot is never the issuing slot, so no write conflict.
         if (doDisp) begin
            busy[freeIdx]  <= 1'b1;
            cmdQ[freeIdx]  <= dispatchCommands_i;
            tagQ[freeIdx]  <= dispatchTag_i;
            src1Q[freeIdx] <= dispatchSrc1_i;
            src2Q[freeIdx] <= dispatchSrc2_i;
            rdy1[freeIdx]  <= dispatchRdy1_i | disp1Hit;
            rdy2[freeIdx]  <= dispatchRdy2_i | disp2Hit;
            val1Q[freeIdx] <= disp1Hit ? cdbVal_i : dispatchVal1_i;
            val2Q[freeIdx] <= disp2Hit ? cdbVal_i : dispatchVal2_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         readyRS_o                    <= 1'b0;
         reservationStationVal1_o     <= '0;
         reservationStationVal2_o     <= '0;
         reservationStationCommands_o <= '0;
         reservationStationTag_o      <= '0;
      end else if (flush_i) begin
         readyRS_o <= 1'b0;
      end else if (!stallRS_i) begin
         readyRS_o <= anyReady;
         if (doIssue) begin
            reservationStationVal1_o     <= val1Q[selIdx];
            reservationStationVal2_o     <= val2Q[selIdx];
            reservationStationCommands_o <= cmdQ[selIdx];
            reservationStationTag_o      <= tagQ[selIdx];
         end
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized bench for alu_reservation_station against a slot-level model,
// plus directed scenarios with hand-computed expectations.
module tb_alu_reservation_station;

   localparam int RSsize = 4;
   localparam int ROBsize = 32;
   localparam int TW = $clog2(ROBsize + 1);
   localparam int CW = $clog2(RSsize + 1);

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          flush_i;
   logic          dispatchValid_i;
   logic [9:0]    dispatchCommands_i;
   logic [TW-1:0] dispatchTag_i;
   logic [63:0]   dispatchVal1_i;
   logic [63:0]   dispatchVal2_i;
   logic          dispatchRdy1_i;
   logic          dispatchRdy2_i;
   logic [TW-1:0] dispatchSrc1_i;
   logic [TW-1:0] dispatchSrc2_i;
   logic          rsFull_o;
   logic [CW-1:0] rsCount_o;
   logic          cdbValid_i;
   logic [TW-1:0] cdbTag_i;
   logic [63:0]   cdbVal_i;
   logic          stallRS_i;
   logic [63:0]   reservationStationVal1_o;
   logic [63:0]   reservationStationVal2_o;
   logic [9:0]    reservationStationCommands_o;
   logic [TW-1:0] reservationStationTag_o;
   logic          readyRS_o;

   always #5 clk_i = ~clk_i;

   alu_reservation_station #(
      .RSsize (RSsize),
      .ROBsize(ROBsize)
   ) dut (
      .clk_i                       (clk_i),
      .reset_i                     (reset_i),
      .flush_i                     (flush_i),
      .dispatchValid_i             (dispatchValid_i),
      .dispatchCommands_i          (dispatchCommands_i),
      .dispatchTag_i               (dispatchTag_i),
      .dispatchVal1_i              (dispatchVal1_i),
      .dispatchVal2_i              (dispatchVal2_i),
      .dispatchRdy1_i              (dispatchRdy1_i),
      .dispatchRdy2_i              (dispatchRdy2_i),
      .dispatchSrc1_i              (dispatchSrc1_i),
      .dispatchSrc2_i              (dispatchSrc2_i),
      .rsFull_o                    (rsFull_o),
      .rsCount_o                   (rsCount_o),
      .cdbValid_i                  (cdbValid_i),
      .cdbTag_i                    (cdbTag_i),
      .cdbVal_i                    (cdbVal_i),
      .stallRS_i                   (stallRS_i),
      .reservationStationVal1_o    (reservationStationVal1_o),
      .reservationStationVal2_o    (reservationStationVal2_o),
      .reservationStationCommands_o(reservationStationCommands_o),
      .reservationStationTag_o     (reservationStationTag_o),
      .readyRS_o                   (readyRS_o)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a bag of slots, each an op waiting on up to two operands.
   typedef struct {
      bit            busy;
      logic [9:0]    cmd;
      logic [TW-1:0] tag;
      logic [63:0]   v1;
      logic [63:0]   v2;
      bit            r1;
      bit            r2;
      logic [TW-1:0] s1;
      logic [TW-1:0] s2;
   } ent_t;

   ent_t          m [RSsize];
   bit            mReady;
   logic [63:0]   mV1, mV2;
   logic [9:0]    mCmd;
   logic [TW-1:0] mTag;
   int            sel, fr;

   function automatic int mCount();
      int n = 0;
      for (int i = 0; i < RSsize; i++) if (m[i].busy) n++;
      return n;
   endfunction

   always @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < RSsize; i++) m[i].busy = 0;
         mReady = 0; mV1 = 0; mV2 = 0; mCmd = 0; mTag = 0;
      end else if (flush_i) begin
         for (int i = 0; i < RSsize; i++) m[i].busy = 0;
         mReady = 0;
      end else begin
         sel = -1;
         fr = -1;
         for (int i = 0; i < RSsize; i++) begin
            if (sel < 0 && m[i].busy && m[i].r1 && m[i].r2) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
         end
         if (!stallRS_i) begin
            mReady = (sel >= 0);
            if (sel >= 0) begin
               mV1 = m[sel].v1; mV2 = m[sel].v2;
               mCmd = m[sel].cmd; mTag = m[sel].tag;
               m[sel].busy = 0;
            end
         end
         if (cdbValid_i)
            for (int i = 0; i < RSsize; i++) if (m[i].busy) begin
               if (!m[i].r1 && m[i].s1 == cdbTag_i) begin
                  m[i].r1 = 1; m[i].v1 = cdbVal_i;
               end
               if (!m[i].r2 && m[i].s2 == cdbTag_i) begin
                  m[i].r2 = 1; m[i].v2 = cdbVal_i;
               end
            end
         if (dispatchValid_i && fr >= 0) begin
            m[fr].busy = 1;
            m[fr].cmd = dispatchCommands_i;
            m[fr].tag = dispatchTag_i;
            m[fr].s1 = dispatchSrc1_i;
            m[fr].s2 = dispatchSrc2_i;
            m[fr].r1 = dispatchRdy1_i ||
                       (cdbValid_i && dispatchSrc1_i == cdbTag_i);
            m[fr].r2 = dispatchRdy2_i ||
                       (cdbValid_i && dispatchSrc2_i == cdbTag_i);
            m[fr].v1 = dispatchRdy1_i ? dispatchVal1_i : cdbVal_i;
            m[fr].v2 = dispatchRdy2_i ? dispatchVal2_i : cdbVal_i;
         end
      end
   end

   always @(negedge clk_i) begin
      if (!reset_i) begin
         chk("rst_ready", 64'(readyRS_o), 64'd0);
         chk("rst_count", 64'(rsCount_o), 64'd0);
         chk("rst_full", 64'(rsFull_o), 64'd0);
         chk("rst_val1", reservationStationVal1_o, 64'd0);
         chk("rst_tag", 64'(reservationStationTag_o), 64'd0);
      end else begin
         chk("ready", 64'(readyRS_o), 64'(mReady));
         chk("count", 64'(rsCount_o), 64'(mCount()));
         chk("full", 64'(rsFull_o), 64'(mCount() == RSsize));
         if (mReady) begin
            chk("val1", reservationStationVal1_o, mV1);
            chk("val2", reservationStationVal2_o, mV2);
            chk("cmd", 64'(reservationStationCommands_o), 64'(mCmd));
            chk("tag", 64'(reservationStationTag_o), 64'(mTag));
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      flush_i = 0; dispatchValid_i = 0; dispatchCommands_i = 0;
      dispatchTag_i = 0; dispatchVal1_i = 0; dispatchVal2_i = 0;
      dispatchRdy1_i = 0; dispatchRdy2_i = 0; dispatchSrc1_i = 0;
      dispatchSrc2_i = 0; cdbValid_i = 0; cdbTag_i = 0; cdbVal_i = 0;
      stallRS_i = 0;
   endtask

   task automatic disp(input int cmd, input int tag,
                       input longint v1, input bit r1, input int s1,
                       input longint v2, input bit r2, input int s2);
      dispatchValid_i = 1;
      dispatchCommands_i = 10'(cmd);
      dispatchTag_i = TW'(tag);
      dispatchVal1_i = 64'(v1); dispatchRdy1_i = r1;
      dispatchSrc1_i = TW'(s1);
      dispatchVal2_i = 64'(v2); dispatchRdy2_i = r2;
      dispatchSrc2_i = TW'(s2);
   endtask

   task automatic cdb(input int tag, input longint v);
      cdbValid_i = 1; cdbTag_i = TW'(tag); cdbVal_i = 64'(v);
   endtask

   task automatic randIn();
      dispatchValid_i = ($urandom_range(0, 99) < 60);
      dispatchCommands_i = 10'($urandom);
      dispatchTag_i = TW'($urandom_range(0, 31));
      dispatchVal1_i = {$urandom, $urandom};
      dispatchVal2_i = {$urandom, $urandom};
      dispatchRdy1_i = 1'($urandom_range(0, 1));
      dispatchRdy2_i = 1'($urandom_range(0, 1));
      dispatchSrc1_i = TW'($urandom_range(0, 7));
      dispatchSrc2_i = TW'($urandom_range(0, 7));
      cdbValid_i = ($urandom_range(0, 99) < 50);
      cdbTag_i = TW'($urandom_range(0, 7));
      cdbVal_i = {$urandom, $urandom};
      stallRS_i = ($urandom_range(0, 99) < 25);
      flush_i = ($urandom_range(0, 99) < 2);
   endtask

   initial begin
      reset_i = 0;
      idle();
      for (int i = 0; i < 3; i++) begin
         randIn();
         tick();
      end
      reset_i = 1;
      idle();
      #1;
      chk("after_rst_ready", 64'(readyRS_o), 64'd0);
      chk("after_rst_count", 64'(rsCount_o), 64'd0);
      chk("after_rst_full", 64'(rsFull_o), 64'd0);
      chk("after_rst_cmd", 64'(reservationStationCommands_o), 64'd0);
      chk("after_rst_val2", reservationStationVal2_o, 64'd0);

      // Minimum latency, both operands ready
      disp(10, 3, 15, 1, 0, 3, 1, 0);
      tick();
      dispatchValid_i = 0;
      chk("lat_n_ready", 64'(readyRS_o), 64'd0);
      chk("lat_n_count", 64'(rsCount_o), 64'd1);
      tick();
      chk("lat_ready", 64'(readyRS_o), 64'd1);
      chk("lat_val1", reservationStationVal1_o, 64'd15);
      chk("lat_val2", reservationStationVal2_o, 64'd3);
      chk("lat_cmd", 64'(reservationStationCommands_o), 64'd10);
      chk("lat_tag", 64'(reservationStationTag_o), 64'd3);
      tick();
      chk("lat_n2_ready", 64'(readyRS_o), 64'd0);
      chk("lat_n2_count", 64'(rsCount_o), 64'd0);

      // CDB wakeup two cycles after dispatch
      disp(1, 5, 0, 0, 7, 4, 1, 0);
      tick();
      dispatchValid_i = 0;
      tick();
      cdb(7, 20);
      tick();
      cdbValid_i = 0;
      chk("wake_edge_ready", 64'(readyRS_o), 64'd0);
      tick();
      chk("wake_ready", 64'(readyRS_o), 64'd1);
      chk("wake_val1", reservationStationVal1_o, 64'd20);
      chk("wake_val2", reservationStationVal2_o, 64'd4);
      chk("wake_tag", 64'(reservationStationTag_o), 64'd5);
      tick();

      // Same-cycle bypass at dispatch
      disp(2, 6, 0, 0, 9, 8, 1, 0);
      cdb(9, 33);
      tick();
      idle();
      chk("byp_edge_ready", 64'(readyRS_o), 64'd0);
      tick();
      chk("byp_ready", 64'(readyRS_o), 64'd1);
      chk("byp_val1", reservationStationVal1_o, 64'd33);
      chk("byp_tag", 64'(reservationStationTag_o), 64'd6);
      tick();

      // Fill, drop, wake one
      for (int i = 0; i < 4; i++) begin
         disp(i, 10 + i, 0, 0, 10 + i, i + 1, 1, 0);
         tick();
      end
      chk("full_flag", 64'(rsFull_o), 64'd1);
      chk("full_count", 64'(rsCount_o), 64'd4);
      disp(9, 14, 1, 1, 0, 1, 1, 0);
      tick();
      idle();
      chk("drop_count", 64'(rsCount_o), 64'd4);
      cdb(12, 99);
      tick();
      cdbValid_i = 0;
      chk("wake_full", 64'(rsFull_o), 64'd1);
      tick();
      chk("unfull_ready", 64'(readyRS_o), 64'd1);
      chk("unfull_tag", 64'(reservationStationTag_o), 64'd12);
      chk("unfull_val1", reservationStationVal1_o, 64'd99);
      chk("unfull_count", 64'(rsCount_o), 64'd3);
      chk("unfull_flag", 64'(rsFull_o), 64'd0);

      // Stall holds the issue register
      stallRS_i = 1;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) cdb(10 + i, 7 + i);
         else cdbValid_i = 0;
         tick();
         chk("stall_ready", 64'(readyRS_o), 64'd1);
         chk("stall_tag", 64'(reservationStationTag_o), 64'd12);
         chk("stall_val1", reservationStationVal1_o, 64'd99);
         chk("stall_count", 64'(rsCount_o), 64'd3);
      end
      stallRS_i = 0;
      tick();
      chk("unstall_tag", 64'(reservationStationTag_o), 64'd10);
      chk("unstall_val1", reservationStationVal1_o, 64'd7);
      chk("unstall_count", 64'(rsCount_o), 64'd2);
      tick();
      chk("unstall2_tag", 64'(reservationStationTag_o), 64'd11);
      tick();
      chk("unstall3_ready", 64'(readyRS_o), 64'd0);
      chk("unstall3_count", 64'(rsCount_o), 64'd1);

      // Flush with a stalled valid issue register
      disp(3, 20, 0, 0, 30, 1, 1, 0);
      tick();
      disp(4, 21, 5, 1, 0, 6, 1, 0);
      tick();
      disp(5, 22, 0, 0, 31, 1, 1, 0);
      tick();
      idle();
      stallRS_i = 1;
      tick();
      chk("pre_flush_ready", 64'(readyRS_o), 64'd1);
      chk("pre_flush_tag", 64'(reservationStationTag_o), 64'd21);
      chk("pre_flush_count", 64'(rsCount_o), 64'd3);
      flush_i = 1;
      tick();
      flush_i = 0;
      stallRS_i = 0;
      chk("flush_ready", 64'(readyRS_o), 64'd0);
      chk("flush_count", 64'(rsCount_o), 64'd0);
      chk("flush_full", 64'(rsFull_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 0) cdb(30, 1);
         else if (i == 1) cdb(13, 2);
         else if (i == 2) cdb(31, 3);
         else cdbValid_i = 0;
         tick();
         chk("post_flush_ready", 64'(readyRS_o), 64'd0);
         chk("post_flush_count", 64'(rsCount_o), 64'd0);
      end

      // Asynchronous reset mid-operation
      disp(6, 25, 11, 1, 0, 12, 1, 0);
      tick();
      disp(7, 26, 0, 0, 2, 1, 1, 0);
      tick();
      idle();
      chk("pre_arst_ready", 64'(readyRS_o), 64'd1);
      chk("pre_arst_count", 64'(rsCount_o), 64'd1);
      #2;
      reset_i = 0;
      #1;
      chk("arst_ready", 64'(readyRS_o), 64'd0);
      chk("arst_count", 64'(rsCount_o), 64'd0);
      chk("arst_val1", reservationStationVal1_o, 64'd0);
      chk("arst_tag", 64'(reservationStationTag_o), 64'd0);
      tick();
      reset_i = 1;

      for (int c = 0; c < 3000; c++) begin
         randIn();
         tick();
      end
      idle();
      for (int i = 0; i < 4; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- ALU-side reservation station; sits between dispatch/rename and the ALU issue/execute stage.
- Buffers dispatched ALU ops until both operands are valid, capturing missing operands from the common data bus (CDB).
- Issues one ready op per cycle over the RS→exec interface: val1/val2/commands/tag/readyRS, with back-pressure via stallRS.

Parameters:
- RSsize, 4, number of station entries.
- ROBsize, 32, ROB depth.
- ROBsizeLog, $clog2(ROBsize+1), width of all ROB tags.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous squash of all entries and the issue register.
- dispatchValid_i  in  1  dispatch request.
- dispatchCommands_i  in  10  command word; bits [4:2] are ALU control.
- dispatchTag_i  in  ROBsizeLog  destination ROB tag.
- dispatchVal1_i, dispatchVal2_i  in  64 each  operand values, meaningful when the matching ready bit is 1.
- dispatchRdy1_i, dispatchRdy2_i  in  1 each  operand already valid.
- dispatchSrc1_i, dispatchSrc2_i  in  ROBsizeLog each  producer tag when the operand is not ready.
- rsFull_o  out  1  no free entry; dispatch is ignored.
- rsCount_o  out  $clog2(RSsize+1)  occupied entries.
- cdbValid_i  in  1  CDB broadcast valid.
- cdbTag_i  in  ROBsizeLog  broadcast tag.
- cdbVal_i  in  64  broadcast value.
- stallRS_i  in  1  execute stage cannot accept; hold the issue register.
- reservationStationVal1_o, reservationStationVal2_o  out  64 each  issued operands.
- reservationStationCommands_o  out  10  issued command.
- reservationStationTag_o  out  ROBsizeLog  issued ROB tag.
- readyRS_o  out  1  issue register holds a valid op.

Behaviour:
- Reset (reset_i=0, async):
  - All entries invalid; rsCount_o=0; rsFull_o=0.
  - Every issue output is 0, including readyRS_o.
- Per-entry state: busy, cmd, tag, val1/rdy1/src1, val2/rdy2/src2.
- Dispatch:
  - Accepted at a rising edge when dispatchValid_i=1 and rsFull_o=0.
  - Written into the lowest-index free entry.
  - rsFull_o = (rsCount_o == RSsize), computed from registered state only. A slot freed by issue this cycle is not reusable until the next cycle.
  - Dispatch while full is dropped silently; the sender must hold it.
- Wakeup:
  - Each cycle cdbValid_i=1, every busy entry with rdyN=0 and srcN==cdbTag_i latches cdbVal_i and sets rdyN.
  - Dispatch bypass: a same-cycle CDB match on a not-ready dispatch operand is captured at dispatch, so the entry is written with rdyN=1.
  - Both operands of one entry may wake on the same broadcast.
- Select:
  - An entry is issuable when busy & rdy1 & rdy2, using registered state.
  - Priority goes to the lowest index.
  - An entry woken or dispatched at edge N is first issuable for edge N+1.
  - Minimum latency: dispatch with both operands ready at edge N → readyRS_o=1 after edge N+1.
- Issue register / handshake:
  - If stallRS_i=1: all issue outputs hold and no entry is freed.
  - If stallRS_i=0 and an issuable entry exists: load its fields, set readyRS_o=1, and clear its busy bit at the same edge.
  - If stallRS_i=0 and nothing is issuable: readyRS_o←0; the other outputs hold their previous values (don't-care).
  - The execute stage captures the outputs at every edge where stallRS_i=0, so each op is presented for exactly one non-stalled edge.
- rsCount_o next value = count + accepted dispatch − issued entry. Simultaneous dispatch and issue leaves the count unchanged.
- Flush:
  - flush_i=1 at an edge clears all busy bits and readyRS_o, and sets rsCount_o=0.
  - Flush has priority over dispatch, wakeup and issue in the same cycle, and overrides stallRS_i.
- A CDB broadcast for a tag that no entry waits on has no effect.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold reset_i=0 with random inputs, then release → readyRS_o=0, rsCount_o=0, rsFull_o=0, all outputs 0.
- Dispatch cmd=10, tag=3, val1=15, val2=3, both ready, at edge N with stallRS_i=0 → after edge N+1: readyRS_o=1, Val1=15, Val2=3, Commands=10, Tag=3. After edge N+2: readyRS_o=0, rsCount_o=0.
- Wakeup and bypass:
  - Dispatch tag=5 with rdy1=0, src1=7, val2=4 ready; two cycles later broadcast cdbTag_i=7, cdbVal_i=20 → entry issues one edge after the broadcast edge with Val1=20, Val2=4.
  - Repeat with the broadcast in the same cycle as dispatch → issues on the next edge.
- Full: dispatch 4 not-ready ops → rsFull_o=1, rsCount_o=4. A 5th dispatch is dropped and the count stays 4. After one wakes and issues, rsFull_o=0 the cycle after.
- Stall: issue-ready op with stallRS_i=1 for 3 cycles → outputs and readyRS_o=1 held constant and the entry stays busy. Deassert stallRS_i → the next ready op (lowest index) loads at that edge.
- Flush: 3 busy entries plus a valid issue register with stallRS_i=1; pulse flush_i → readyRS_o=0 and rsCount_o=0 after the edge. A later CDB broadcast of the old tags causes no issue.
